// File: rtl/jk_reg_ctrl_pkg.sv
// jk_reg_ctrl shared definitions.
// Opcodes and FSM state encoding.
package jk_reg_ctrl_pkg;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_CLEAR  = 3'b001;
  localparam logic [2:0] OP_SET    = 3'b010;
  localparam logic [2:0] OP_LOAD   = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam logic [2:0] OP_UP     = 3'b101;
  localparam logic [2:0] OP_DOWN   = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/jk_reg_ctrl_jkff.sv
// jkff: single JK flip-flop cell.
// Async active-high reset clears Q.
module jkff (
  input  logic CLK,
  input  logic RESET,
  input  logic J,
  input  logic K,
  output logic Q
);

  // hold / reset / set / toggle on each rising edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Q <= 1'b0;
    end else begin
      unique case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_reg_ctrl.sv
// jk_reg_ctrl: command sequencer driving a bank of jkff cells.
// Define JK_REG_CTRL_DOWN_EN to enable opcode 110 (COUNT_DOWN).
module jk_reg_ctrl
  import jk_reg_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [CNT_W-1:0] CMD_STEPS,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE
);

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]   rem;
  logic [WIDTH-1:0]   j;
  logic [WIDTH-1:0]   k;
  logic [WIDTH-1:0]   up_t;
  logic               cnt_op;
  logic               has_steps;

`ifdef JK_REG_CTRL_DOWN_EN
  logic [WIDTH-1:0]   dn_t;

  // down-count toggle: bit i flips when all lower bits are zero
  always_comb begin
    logic run;
    run  = 1'b1;
    dn_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dn_t[i] = run;
      run     = run & ~Q[i];
    end
  end

  assign cnt_op = (op_q == OP_UP) || (op_q == OP_DOWN);
`else
  assign cnt_op = (op_q == OP_UP);
`endif

  assign has_steps = (rem != '0);

  // up-count toggle: bit i flips when all lower bits are one
  always_comb begin
    logic run;
    run  = 1'b1;
    up_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = run;
      run     = run & Q[i];
    end
  end

  // per-bit J/K; zero outside EXEC so the bank holds
  always_comb begin
    j = '0;
    k = '0;
    if (state == ST_EXEC) begin
      unique case (1'b1)
        op_q == OP_CLEAR: k = '1;
        op_q == OP_SET:   j = '1;
        op_q == OP_LOAD: begin
          j = data_q;
          k = ~data_q;
        end
        op_q == OP_TOGGLE: begin
          j = data_q;
          k = data_q;
        end
        op_q == OP_UP: begin
          if (has_steps) begin
            j = up_t;
            k = up_t;
          end
        end
`ifdef JK_REG_CTRL_DOWN_EN
        op_q == OP_DOWN: begin
          if (has_steps) begin
            j = dn_t;
            k = dn_t;
          end
        end
`endif
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  // command FSM with registered handshake/status outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      data_q    <= '0;
      rem       <= '0;
      CMD_READY <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (CMD_VALID) begin
            op_q      <= CMD_OP;
            data_q    <= CMD_DATA;
            rem       <= CMD_STEPS;
            state     <= ST_EXEC;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt_op && (rem > CNT_W'(1))) begin
            rem <= rem - CNT_W'(1);
          end else begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          DONE      <= 1'b0;
          CMD_READY <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          CMD_READY <= 1'b1;
          BUSY      <= 1'b0;
          DONE      <= 1'b0;
        end
      endcase
    end
  end

  // one jkff per register bit
  for (genvar g = 0; g < WIDTH; g++) begin : g_ff
    jkff u_ff (
      .CLK   (CLK),
      .RESET (RESET),
      .J     (j[g]),
      .K     (k[g]),
      .Q     (Q[g])
    );
  end

endmodule

// File: tb/tb_jk_reg_ctrl.sv
// tb_jk_reg_ctrl: directed test of jk_reg_ctrl.
// Honours JK_REG_CTRL_DOWN_EN for the opcode 110 case.
module tb_jk_reg_ctrl;

  logic       CLK;
  logic       RESET;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [2:0] CMD_OP;
  logic [3:0] CMD_DATA;
  logic [7:0] CMD_STEPS;
  logic [3:0] Q;
  logic       BUSY;
  logic       DONE;

  int n_chk;
  int n_fail;

  jk_reg_ctrl #(
    .WIDTH (4),
    .CNT_W (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_DATA  (CMD_DATA),
    .CMD_STEPS (CMD_STEPS),
    .Q         (Q),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic status(input string tag,
                        input logic [3:0] q,
                        input logic rdy,
                        input logic bsy,
                        input logic dn);
    chk({tag, "_q"},     32'(Q),         32'(q));
    chk({tag, "_ready"}, 32'(CMD_READY), 32'(rdy));
    chk({tag, "_busy"},  32'(BUSY),      32'(bsy));
    chk({tag, "_done"},  32'(DONE),      32'(dn));
  endtask

  // accept on the next edge, release VALID, leave sampling point after edge t
  task automatic issue(input logic [2:0] op,
                       input logic [3:0] data,
                       input logic [7:0] steps);
    CMD_OP    = op;
    CMD_DATA  = data;
    CMD_STEPS = steps;
    CMD_VALID = 1'b1;
    step();
    CMD_VALID = 1'b0;
  endtask

  // single-shot command: checks edge t, t+1, t+2
  task automatic single(input string tag,
                        input logic [2:0] op,
                        input logic [3:0] data,
                        input logic [3:0] q_before,
                        input logic [3:0] q_after);
    issue(op, data, 8'd0);
    status({tag, "_t0"}, q_before, 1'b0, 1'b1, 1'b0);
    step();
    status({tag, "_t1"}, q_after, 1'b0, 1'b0, 1'b1);
    step();
    status({tag, "_t2"}, q_after, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    RESET     = 1'b1;
    CMD_VALID = 1'b0;
    CMD_OP    = 3'b000;
    CMD_DATA  = 4'h0;
    CMD_STEPS = 8'd0;

    step();
    status("rst", 4'b0000, 1'b1, 1'b0, 1'b0);
    RESET = 1'b0;
    step();
    status("idle", 4'b0000, 1'b1, 1'b0, 1'b0);

    single("load_a", 3'b011, 4'b1010, 4'b0000, 4'b1010);

    single("load_e", 3'b011, 4'b1110, 4'b1010, 4'b1110);
    issue(3'b101, 4'b0000, 8'd3);
    status("up_t0", 4'b1110, 1'b0, 1'b1, 1'b0);
    step();
    status("up_t1", 4'b1111, 1'b0, 1'b1, 1'b0);
    step();
    status("up_t2", 4'b0000, 1'b0, 1'b1, 1'b0);
    step();
    status("up_t3", 4'b0001, 1'b0, 1'b0, 1'b1);
    step();
    status("up_t4", 4'b0001, 1'b1, 1'b0, 1'b0);

    single("load_5", 3'b011, 4'b0101, 4'b0001, 4'b0101);
    single("toggle", 3'b100, 4'b0011, 4'b0101, 4'b0110);
    single("set",    3'b010, 4'b0000, 4'b0110, 4'b1111);
    single("clear",  3'b001, 4'b1010, 4'b1111, 4'b0000);
    single("nop",    3'b000, 4'b1111, 4'b0000, 4'b0000);

    single("load_6", 3'b011, 4'b0110, 4'b0000, 4'b0110);
    CMD_OP    = 3'b101;
    CMD_DATA  = 4'b0000;
    CMD_STEPS = 8'd0;
    CMD_VALID = 1'b1;
    step();
    status("up0_t0", 4'b0110, 1'b0, 1'b1, 1'b0);
    CMD_OP    = 3'b011;
    CMD_DATA  = 4'b1001;
    step();
    status("up0_t1", 4'b0110, 1'b0, 1'b0, 1'b1);
    step();
    status("up0_t2", 4'b0110, 1'b1, 1'b0, 1'b0);
    step();
    CMD_VALID = 1'b0;
    status("held_t0", 4'b0110, 1'b0, 1'b1, 1'b0);
    step();
    status("held_t1", 4'b1001, 1'b0, 1'b0, 1'b1);
    step();
    status("held_t2", 4'b1001, 1'b1, 1'b0, 1'b0);

    single("load_1", 3'b011, 4'b0001, 4'b1001, 4'b0001);
    issue(3'b110, 4'b0000, 8'd2);
    status("dn_t0", 4'b0001, 1'b0, 1'b1, 1'b0);
    step();
`ifdef JK_REG_CTRL_DOWN_EN
    status("dn_t1", 4'b0000, 1'b0, 1'b1, 1'b0);
    step();
    status("dn_t2", 4'b1111, 1'b0, 1'b0, 1'b1);
    step();
    status("dn_t3", 4'b1111, 1'b1, 1'b0, 1'b0);
`else
    status("dn_t1", 4'b0001, 1'b0, 1'b0, 1'b1);
    step();
    status("dn_t2", 4'b0001, 1'b1, 1'b0, 1'b0);
`endif

    single("rsvd", 3'b111, 4'b1111, Q, Q);

    single("load_0", 3'b011, 4'b0000, Q, 4'b0000);
    issue(3'b101, 4'b0000, 8'd10);
    step();
    step();
    step();
    step();
    status("abort_pre", 4'b0100, 1'b0, 1'b1, 1'b0);
    RESET = 1'b1;
    #1;
    status("abort_now", 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    RESET = 1'b0;
    step();
    status("abort_a1", 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    status("abort_a2", 4'b0000, 1'b1, 1'b0, 1'b0);

    RESET     = 1'b1;
    CMD_OP    = 3'b010;
    CMD_DATA  = 4'b0000;
    CMD_STEPS = 8'd0;
    CMD_VALID = 1'b1;
    step();
    status("rv_rst", 4'b0000, 1'b1, 1'b0, 1'b0);
    RESET = 1'b0;
    step();
    CMD_VALID = 1'b0;
    status("rv_t0", 4'b0000, 1'b0, 1'b1, 1'b0);
    step();
    status("rv_t1", 4'b1111, 1'b0, 1'b0, 1'b1);
    step();
    status("rv_t2", 4'b1111, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
